// File: rtl/vigna_m_pkg.sv
// vigna_m_pkg: shared definitions for the RV32M issue block.
//   - OPCODE_OP / FUNCT7_MULDIV: fields identifying an M-extension instruction
//   - m_funct3_e: funct3 encodings MUL..REMU
//   - m_state_e: issue FSM states (IDLE, REQ, DRAIN, WB)
//   - is_m_instr(): decode helper
package vigna_m_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } m_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WB    = 2'd3
  } m_state_e;

  function automatic logic is_m_instr(input logic [31:0] instr);
    return (instr[6:0] == OPCODE_OP) && (instr[31:25] == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/vigna_m_fixup.sv
// vigna_m_fixup: combinational detector for the RISC-V div/rem corner cases
// that have architecturally defined results and need no coprocessor.
//   func  [2:0]  in   funct3 of the operation
//   op1   [31:0] in   dividend
//   op2   [31:0] in   divisor
//   hit          out  1 = result is resolved locally
//   value [31:0] out  local result (valid when hit)
// Parameter FIXUP_DIV: 0 forces hit low so every op goes to the coprocessor.
module vigna_m_fixup
  import vigna_m_pkg::*;
#(
  parameter bit FIXUP_DIV = 1'b1
) (
  input  logic [2:0]  func,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        hit,
  output logic [31:0] value
);

  logic div_zero;
  logic ovf;

  always_comb begin
    hit      = 1'b0;
    value    = 32'd0;
    div_zero = (op2 == 32'd0);
    // Only signed div/rem can overflow: most-negative / -1.
    ovf      = (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
    if (FIXUP_DIV && func[2]) begin
      if (div_zero) begin
        hit   = 1'b1;
        // func[1] separates rem/remu (returns dividend) from div/divu (all ones).
        value = func[1] ? op1 : 32'hFFFF_FFFF;
      end else if (ovf && (func == F3_DIV)) begin
        hit   = 1'b1;
        value = 32'h8000_0000;
      end else if (ovf && (func == F3_REM)) begin
        hit   = 1'b1;
        value = 32'd0;
      end
    end
  end

endmodule

// File: rtl/vigna_m_issue.sv
// vigna_m_issue: execute-stage initiator for the RV32M coprocessor.
// Decodes M instructions, issues a held request to the coprocessor, stalls
// the core while busy and returns a one-cycle writeback pulse. Div/rem corner
// cases are answered locally; every request is bounded by a watchdog.
//
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready, instr, rs1_val, rs2_val : instruction from the core
//   flush                                      : kill the in-flight op
//   busy                                       : stall request (state != IDLE)
//   wb_valid, wb_rd, wb_data                   : writeback pulse
//   err                                        : one-cycle pulse on watchdog abort
//   co_valid/co_ready, co_func, co_op1, co_op2, co_result : coprocessor side
//
// Coprocessor handshake: co_valid is registered and stays high with stable
// co_func/co_op1/co_op2 until the cycle co_ready pulses; co_valid is low in
// the following cycle. co_ready is a completion pulse and co_result is only
// meaningful in that cycle.
//
// Optional build macro VIGNA_M_ISSUE_CACHE_EN: remembers the last completed
// coprocessor op and answers an identical op without a request.
module vigna_m_issue
  import vigna_m_pkg::*;
#(
  parameter int WDOG_CYCLES = 1024,
  parameter bit FIXUP_DIV   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic        flush,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err,
  output logic        co_valid,
  input  logic        co_ready,
  output logic [2:0]  co_func,
  output logic [31:0] co_op1,
  output logic [31:0] co_op2,
  input  logic [31:0] co_result
);

  localparam logic [31:0] WDOG_LIM = 32'(WDOG_CYCLES);

  m_state_e    state_q;
  logic        hold_q;     // first cycle of a fast-path WB: output not yet due
  logic [31:0] wd_cnt;
  logic [31:0] wd_next;
  logic        wd_expire;
  logic        accept;
  logic        fix_hit;
  logic [31:0] fix_val;
  logic        cache_hit;
  logic [31:0] cache_val;

  // rs1/rs2 register-number fields are not needed here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[24:15];

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign accept   = in_valid && in_ready && is_m_instr(instr);
  assign wb_valid = (state_q == ST_WB) && !hold_q && !flush;

  assign wd_next   = wd_cnt + 32'd1;
  // >= so a timeout reached on the same edge a flush moves us to DRAIN
  // still fires on the next DRAIN cycle.
  assign wd_expire = (WDOG_CYCLES != 0) && (wd_next >= WDOG_LIM);

  vigna_m_fixup #(.FIXUP_DIV(FIXUP_DIV)) u_fixup (
    .func  (instr[14:12]),
    .op1   (rs1_val),
    .op2   (rs2_val),
    .hit   (fix_hit),
    .value (fix_val)
  );

`ifdef VIGNA_M_ISSUE_CACHE_EN
  logic        c_valid;
  logic [2:0]  c_func;
  logic [31:0] c_op1;
  logic [31:0] c_op2;
  logic [31:0] c_res;
  logic        ev_complete;
  logic        ev_abort;

  assign cache_hit = c_valid && (c_func == instr[14:12]) &&
                     (c_op1 == rs1_val) && (c_op2 == rs2_val);
  assign cache_val = c_res;

  assign ev_complete = (state_q == ST_REQ) && co_ready && !flush;
  assign ev_abort    = ((state_q == ST_REQ) && flush && co_ready) ||
                       ((state_q == ST_REQ) && !flush && !co_ready && wd_expire) ||
                       ((state_q == ST_DRAIN) && (co_ready || wd_expire));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_func  <= 3'd0;
      c_op1   <= 32'd0;
      c_op2   <= 32'd0;
      c_res   <= 32'd0;
    end else if (ev_complete) begin
      c_valid <= 1'b1;
      c_func  <= co_func;
      c_op1   <= co_op1;
      c_op2   <= co_op2;
      c_res   <= co_result;
    end else if (ev_abort) begin
      c_valid <= 1'b0;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_val = 32'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hold_q   <= 1'b0;
      wd_cnt   <= 32'd0;
      co_valid <= 1'b0;
      co_func  <= 3'd0;
      co_op1   <= 32'd0;
      co_op2   <= 32'd0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            co_func <= instr[14:12];
            co_op1  <= rs1_val;
            co_op2  <= rs2_val;
            wb_rd   <= instr[11:7];
            wd_cnt  <= 32'd0;
            if (fix_hit) begin
              wb_data <= fix_val;
              hold_q  <= 1'b1;
              state_q <= ST_WB;
            end else if (cache_hit) begin
              wb_data <= cache_val;
              hold_q  <= 1'b1;
              state_q <= ST_WB;
            end else begin
              co_valid <= 1'b1;
              state_q  <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          wd_cnt <= wd_next;
          if (flush && co_ready) begin
            // Completion and kill on the same edge: drop the result.
            co_valid <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (flush) begin
            // Request already visible; keep it up until the coprocessor answers.
            state_q <= ST_DRAIN;
          end else if (co_ready) begin
            wb_data  <= co_result;
            co_valid <= 1'b0;
            hold_q   <= 1'b0;
            state_q  <= ST_WB;
          end else if (wd_expire) begin
            wb_data  <= 32'd0;
            co_valid <= 1'b0;
            err      <= 1'b1;
            hold_q   <= 1'b0;
            state_q  <= ST_WB;
          end
        end
        ST_DRAIN: begin
          wd_cnt <= wd_next;
          if (co_ready) begin
            co_valid <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (wd_expire) begin
            co_valid <= 1'b0;
            err      <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        ST_WB: begin
          if (hold_q && !flush) begin
            hold_q <= 1'b0;
          end else begin
            // Either the pulse was presented this cycle or flush killed it.
            hold_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
